// File: rtl/sort_pkt_checker.sv
// sort_pkt_checker: Avalon-ST sink for the sort pipeline output.
// Checks framing, per-packet length against MAX_PKT_LEN and non-decreasing
// unsigned word order. It emits one registered status record per packet and
// keeps wrapping packet and error counters.
// Optional macro SORT_CHK_BACKPRESSURE_EN: when defined, a 16-bit LFSR
// drives snk_ready_o with pseudo-random backpressure. When it is undefined,
// the sink is always ready once it leaves reset.
module sort_pkt_checker #(
    parameter int          DWIDTH      = 32,
    parameter int          MAX_PKT_LEN = 128,
    parameter int          CNT_W       = 32,
    parameter logic [15:0] BP_SEED     = 16'hACE1,
    localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 2)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  pkt_len_o,
    output logic [2:0]        pkt_err_o,
    output logic              stray_o,
    output logic [CNT_W-1:0]  pkt_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    // A zero seed would lock the LFSR at zero, so it is rejected at elaboration.
    if (BP_SEED == 16'h0000) begin : g_bad_seed
        $error("sort_pkt_checker: BP_SEED must be non-zero");
    end

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   prev_q, prev_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          err_q, err_d;
    logic                pend_q, pend_d;
    logic                xfer;
    logic                rpt_now;
    logic [LEN_W-1:0]    rpt_now_len;
    logic [2:0]          rpt_now_err;
    logic                trunc_eop;
    logic                rpt_vld;
    logic [LEN_W-1:0]    rpt_len;
    logic [2:0]          rpt_err;
    logic                stray_d;

    assign xfer = snk_valid_i & snk_ready_o;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, packet tracking and the report generated by this transfer.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        len_d       = len_q;
        err_d       = err_q;
        rpt_now     = 1'b0;
        rpt_now_len = len_q;
        rpt_now_err = err_q;
        trunc_eop   = 1'b0;
        stray_d     = 1'b0;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (snk_startofpacket_i) begin
                        prev_d = snk_data_i;
                        len_d  = LEN_ONE;
                        err_d  = 3'b000;
                        if (snk_endofpacket_i) begin
                            rpt_now     = 1'b1;
                            rpt_now_len = LEN_ONE;
                            rpt_now_err = 3'b000;
                        end else begin
                            state_d = IN_PKT;
                        end
                    end else begin
                        stray_d = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (snk_startofpacket_i) begin
                        // Truncate the open packet; this word opens the next one.
                        rpt_now     = 1'b1;
                        rpt_now_len = len_q;
                        rpt_now_err = err_q | 3'b100;
                        prev_d      = snk_data_i;
                        len_d       = LEN_ONE;
                        err_d       = 3'b000;
                        if (snk_endofpacket_i) begin
                            trunc_eop = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        if (snk_data_i < prev_q) begin
                            err_d[0] = 1'b1;
                        end
                        prev_d = snk_data_i;
                        if (len_q < LEN_SAT) begin
                            len_d = len_q + LEN_ONE;
                        end
                        if (len_d == LEN_SAT) begin
                            err_d[1] = 1'b1;
                        end
                        if (snk_endofpacket_i) begin
                            rpt_now     = 1'b1;
                            rpt_now_len = len_d;
                            rpt_now_err = err_d;
                            state_d     = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Report arbitration. A pending clean 1-word report left by a truncating
    // SOP+EOP goes out first. pend_q implies IDLE, so any report produced in
    // the same cycle is itself a clean 1-word packet and takes the pending slot.
    always_comb begin
        rpt_vld = rpt_now | pend_q;
        if (pend_q) begin
            rpt_len = LEN_ONE;
            rpt_err = 3'b000;
            pend_d  = rpt_now | trunc_eop;
        end else begin
            rpt_len = rpt_now_len;
            rpt_err = rpt_now_err;
            pend_d  = trunc_eop;
        end
    end

    // Packet tracking registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            prev_q <= '0;
            len_q  <= '0;
            err_q  <= 3'b000;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            len_q  <= len_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    // Registered status record, stray pulse and counters.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            done_o    <= 1'b0;
            pkt_len_o <= '0;
            pkt_err_o <= 3'b000;
            stray_o   <= 1'b0;
            pkt_cnt_o <= '0;
            err_cnt_o <= '0;
        end else begin
            done_o  <= rpt_vld;
            stray_o <= stray_d;
            if (rpt_vld) begin
                pkt_len_o <= rpt_len;
                pkt_err_o <= rpt_err;
                pkt_cnt_o <= pkt_cnt_o + 1'b1;
                if (rpt_err != 3'b000) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

`ifdef SORT_CHK_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (right-shifting form); ready is
    // high when either of the two low bits is set, about 75% of cycles.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lfsr_q      <= BP_SEED;
            snk_ready_o <= 1'b0;
        end else begin
            lfsr_q      <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            snk_ready_o <= lfsr_q[0] | lfsr_q[1];
        end
    end
`else
    // Always ready from the first edge after reset release.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            snk_ready_o <= 1'b0;
        end else begin
            snk_ready_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sort_pkt_checker.sv
// Self-checking bench for sort_pkt_checker. A packet-level reference model
// holds each open packet as a word list and derives length and error bits
// from the whole packet when it closes. Reports are checked in order as
// done_o pulses. Works with and without SORT_CHK_BACKPRESSURE_EN.
module tb_sort_pkt_checker;

    localparam int          DWIDTH = 32;
    localparam int          MAX    = 128;
    localparam int          CNT_W  = 32;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          LEN_W  = $clog2(MAX + 2);

    logic              clk_i    = 1'b0;
    logic              arst_n_i = 1'b0;
    logic [DWIDTH-1:0] snk_data_i = '0;
    logic              snk_startofpacket_i = 1'b0;
    logic              snk_endofpacket_i   = 1'b0;
    logic              snk_valid_i         = 1'b0;
    logic              snk_ready_o;
    logic              done_o;
    logic [LEN_W-1:0]  pkt_len_o;
    logic [2:0]        pkt_err_o;
    logic              stray_o;
    logic [CNT_W-1:0]  pkt_cnt_o;
    logic [CNT_W-1:0]  err_cnt_o;

    sort_pkt_checker #(
        .DWIDTH      (DWIDTH),
        .MAX_PKT_LEN (MAX),
        .CNT_W       (CNT_W),
        .BP_SEED     (SEED)
    ) dut (
        .clk_i               (clk_i),
        .arst_n_i            (arst_n_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .done_o              (done_o),
        .pkt_len_o           (pkt_len_o),
        .pkt_err_o           (pkt_err_o),
        .stray_o             (stray_o),
        .pkt_cnt_o           (pkt_cnt_o),
        .err_cnt_o           (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [2:0]       err;
    } rpt_t;

    rpt_t              exp_q[$];
    logic [DWIDTH-1:0] cur[$];
    bit                mdl_in_pkt;
    int                mdl_pkt_cnt;
    int                mdl_err_cnt;
    int                stray_exp;
    int                stray_seen;
    logic [LEN_W-1:0]  last_len;
    logic [2:0]        last_err;
    logic              ready_exp;
    int                checks;
    int                errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Close the word list `cur` into an expected status record.
    function automatic void push_report(input logic [2:0] extra);
        rpt_t r;
        int   n;
        logic ord;
        n   = cur.size();
        ord = 1'b0;
        for (int i = 1; i < n; i++) begin
            if (cur[i] < cur[i-1]) ord = 1'b1;
        end
        r.len = (n > MAX) ? LEN_W'(MAX + 1) : LEN_W'(n);
        r.err = extra | ((n > MAX) ? 3'b010 : 3'b000) | {2'b00, ord};
        exp_q.push_back(r);
    endfunction

    // Packet-level reaction to one accepted word.
    function automatic void model_accept(input logic [DWIDTH-1:0] d, input logic sop, input logic eop);
        if (!mdl_in_pkt) begin
            if (sop) begin
                cur.delete();
                cur.push_back(d);
                if (eop) push_report(3'b000);
                else mdl_in_pkt = 1'b1;
            end else begin
                stray_exp++;
            end
        end else if (sop) begin
            push_report(3'b100);
            cur.delete();
            cur.push_back(d);
            if (eop) begin
                push_report(3'b000);
                mdl_in_pkt = 1'b0;
            end
        end else begin
            cur.push_back(d);
            if (eop) begin
                push_report(3'b000);
                mdl_in_pkt = 1'b0;
            end
        end
    endfunction

`ifdef SORT_CHK_BACKPRESSURE_EN
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Expected ready: the LFSR pattern from the seed.
    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lfsr_m    <= SEED;
            ready_exp <= 1'b0;
        end else begin
            ready_exp <= lfsr_m[0] | lfsr_m[1];
            lfsr_m    <= lfsr_next(lfsr_m);
        end
    end
`else
    // Expected ready: high from the first edge after reset release.
    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) ready_exp <= 1'b0;
        else           ready_exp <= 1'b1;
    end
`endif

    // Output monitor on the falling edge: ready pattern, reports in order,
    // held status fields and counters.
    always @(negedge clk_i) begin : monitor
        rpt_t r;
        if (arst_n_i) begin
            check("ready", snk_ready_o, ready_exp);
            if (stray_o) stray_seen++;
            if (done_o) begin
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    mdl_pkt_cnt++;
                    if (r.err != 3'b000) mdl_err_cnt++;
                    last_len = r.len;
                    last_err = r.err;
                end
            end
            check("pkt_len", pkt_len_o, last_len);
            check("pkt_err", pkt_err_o, last_err);
            check("pkt_cnt", pkt_cnt_o, mdl_pkt_cnt);
            check("err_cnt", err_cnt_o, mdl_err_cnt);
        end
    end

    // Offer one word starting at a falling edge; hold it until accepted.
    task automatic send(input logic [DWIDTH-1:0] d, input logic sop, input logic eop);
        bit taken;
        taken = 1'b0;
        snk_data_i          = d;
        snk_startofpacket_i = sop;
        snk_endofpacket_i   = eop;
        snk_valid_i         = 1'b1;
        for (int t = 0; t < 64 && !taken; t++) begin
            if (snk_ready_o) begin
                @(posedge clk_i);
                model_accept(d, sop, eop);
                taken = 1'b1;
            end else begin
                @(posedge clk_i);
            end
            @(negedge clk_i);
        end
        snk_valid_i = 1'b0;
        check("xfer_in_budget", taken, 1);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk_i);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_stray_count"}, stray_seen, stray_exp);
    endtask

    // Assert reset, check every output immediately, then release.
    task automatic do_reset();
        arst_n_i    = 1'b0;
        snk_valid_i = 1'b0;
        exp_q.delete();
        cur.delete();
        mdl_in_pkt  = 1'b0;
        mdl_pkt_cnt = 0;
        mdl_err_cnt = 0;
        stray_exp   = 0;
        stray_seen  = 0;
        last_len    = '0;
        last_err    = 3'b000;
        #1;
        check("rst_ready", snk_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_len", pkt_len_o, 0);
        check("rst_err", pkt_err_o, 0);
        check("rst_stray", stray_o, 0);
        check("rst_pkt_cnt", pkt_cnt_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int                kind;
        int                n;
        bit                trunc;
        bit                asc;
        logic [DWIDTH-1:0] d;

        checks = 0;
        errors = 0;
        do_reset();

        // Ascending packet with an equal pair.
        send(32'd1, 1'b1, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd7, 1'b0, 1'b1);
        check("p1_done", done_o, 1);
        check("p1_len", pkt_len_o, 4);
        check("p1_err", pkt_err_o, 3'b000);
        check("p1_pkt_cnt", pkt_cnt_o, 1);
        check("p1_err_cnt", err_cnt_o, 0);
        @(negedge clk_i);
        check("p1_done_single", done_o, 0);
        drain("p1");

        // Order violation.
        send(32'd5, 1'b1, 1'b0);
        send(32'd3, 1'b0, 1'b0);
        send(32'd9, 1'b0, 1'b1);
        check("p2_len", pkt_len_o, 3);
        check("p2_err", pkt_err_o, 3'b001);
        check("p2_err_cnt", err_cnt_o, 1);
        drain("p2");

        // Overlength: MAX+3 ascending words.
        for (int i = 0; i < MAX + 3; i++) begin
            send(DWIDTH'(i * 2), 1'(i == 0), 1'(i == MAX + 2));
        end
        check("long_len", pkt_len_o, MAX + 1);
        check("long_err", pkt_err_o, 3'b010);
        check("long_pkt_cnt", pkt_cnt_o, 3);
        drain("long");

        // Truncating SOP+EOP: two reports on consecutive cycles.
        send(32'd4, 1'b1, 1'b0);
        send(32'd6, 1'b0, 1'b0);
        send(32'd1, 1'b1, 1'b1);
        check("trunc_done", done_o, 1);
        check("trunc_len", pkt_len_o, 2);
        check("trunc_err", pkt_err_o, 3'b100);
        @(negedge clk_i);
        check("one_done", done_o, 1);
        check("one_len", pkt_len_o, 1);
        check("one_err", pkt_err_o, 3'b000);
        check("one_pkt_cnt", pkt_cnt_o, 5);
        check("one_err_cnt", err_cnt_o, 3);
        drain("trunc");

        // Stray words in IDLE, with and without EOP.
        send(32'd8, 1'b0, 1'b0);
        check("stray_pulse", stray_o, 1);
        check("stray_no_done", done_o, 0);
        @(negedge clk_i);
        check("stray_single", stray_o, 0);
        send(32'd9, 1'b0, 1'b1);
        check("stray_eop_pulse", stray_o, 1);
        check("stray_pkt_cnt", pkt_cnt_o, 5);
        drain("stray");

        // Truncating SOP+EOP followed at once by another 1-word packet.
        send(32'd20, 1'b1, 1'b0);
        send(32'd21, 1'b0, 1'b0);
        send(32'd22, 1'b1, 1'b1);
        send(32'd23, 1'b1, 1'b1);
        drain("trunc_b2b");
        check("trunc_b2b_cnt", pkt_cnt_o, 8);

        // 100 single-word packets with valid held high.
        for (int i = 0; i < 100; i++) begin
            send($urandom, 1'b1, 1'b1);
        end
        drain("single");
        check("single_pkt_cnt", pkt_cnt_o, 108);
        check("single_err_cnt", err_cnt_o, 4);

        // Randomised packets, truncations and strays.
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2 && !mdl_in_pkt) begin
                send($urandom, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                n     = $urandom_range(1, 10);
                trunc = ($urandom_range(0, 4) == 0);
                asc   = 1'($urandom_range(0, 1));
                d     = DWIDTH'($urandom_range(0, 100));
                for (int i = 0; i < n; i++) begin
                    send(d, 1'(i == 0), 1'((i == n - 1) && !trunc));
                    d = asc ? d + DWIDTH'($urandom_range(0, 3)) : DWIDTH'($urandom);
                end
            end
        end
        if (mdl_in_pkt) send(32'hFFFF_FFFF, 1'b0, 1'b1);
        drain("random");

        // Reset mid-packet: no report, immediate return to reset values.
        send(32'd10, 1'b1, 1'b0);
        send(32'd11, 1'b0, 1'b0);
        #2;
        do_reset();
        send(32'd3, 1'b1, 1'b0);
        send(32'd4, 1'b0, 1'b1);
        check("post_rst_done", done_o, 1);
        check("post_rst_len", pkt_len_o, 2);
        check("post_rst_err", pkt_err_o, 3'b000);
        check("post_rst_pkt_cnt", pkt_cnt_o, 1);
        check("post_rst_err_cnt", err_cnt_o, 0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
